// File: rtl/ov7670_stream_tx_if.sv
// Camera-side and frame-store-side signals of the OV7670 stream transmitter.
// master = transmitter, slave = frame store plus camera receiver.
interface ov7670_stream_tx_if;
  logic        pix_rd;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;

  modport master (
    output pix_rd, pix_x, pix_y, cam_vsync, cam_href, cam_data,
    input  pix_data
  );

  modport slave (
    input  pix_rd, pix_x, pix_y, cam_vsync, cam_href, cam_data,
    output pix_data
  );
endinterface

// File: rtl/ov7670_stream_tx.sv
// OV7670 parallel-output timing generator fed from a synchronous-read frame store.
// Define CAM_TX_PATTERN_EN to add the internal eight-bar colour pattern source.
module ov7670_stream_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               pattern_sel,
  ov7670_stream_tx_if.master bus,
  output logic               frame_done,
  output logic               busy
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LINE);

  localparam logic [HW-1:0] H_LAST   = HW'(LINE - 1);
  localparam logic [HW-1:0] H_PRE    = HW'(LINE - 2);
  localparam logic [HW-1:0] H_HREF   = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] H_RD_END = HW'(2 * H_ACTIVE - 2);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  // state/hcnt/vcnt name the cycle the outputs will show next; all outputs are
  // registered from them, so the counters lead the pins by exactly one cycle.
  state_t        state;
  logic [HW-1:0] hcnt;
  logic [9:0]    vcnt;
  logic [9:0]    v_last;
  logic [7:0]    lo_byte;
  logic [15:0]   pixel;
  logic          rd_en;
  logic          line_end, phase_end, in_href, rd_pix, rd_pre;

  always_comb begin
    // NOTE: default assigned first so every path drives v_last and no latch is inferred.
    v_last = '0;
    case (state)
      VSYNC:   v_last = 10'(VSYNC_LINES - 1);
      VBACK:   v_last = 10'(V_BACK - 1);
      ACTIVE:  v_last = 10'(V_ACTIVE - 1);
      VFRONT:  v_last = 10'(V_FRONT - 1);
      default: v_last = '0;
    endcase
  end

  assign line_end  = (hcnt == H_LAST);
  assign phase_end = line_end && (vcnt == v_last);
  assign in_href   = (state == ACTIVE) && (hcnt < H_HREF);
  assign rd_pix    = (state == ACTIVE) && !hcnt[0] && (hcnt < H_RD_END);
  // Pixel 0 of each line is fetched two cycles before href rises, in the previous blank.
  assign rd_pre    = (hcnt == H_PRE) &&
                     (((state == VBACK)  && (vcnt == 10'(V_BACK - 1))) ||
                      ((state == ACTIVE) && (vcnt != 10'(V_ACTIVE - 1))));

`ifdef CAM_TX_PATTERN_EN
  localparam logic [6:0] BAR_LAST = 7'(H_ACTIVE / 8 - 1);

  logic        pat_mode;
  logic [6:0]  bar_cnt;
  logic [2:0]  bar_idx;
  logic [15:0] bar_colour;

  always_comb begin
    bar_colour = 16'h0000;
    case (bar_idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_mode <= 1'b0;
      bar_cnt  <= '0;
      bar_idx  <= '0;
    end else begin
      if (run && ((state == IDLE) || ((state == VFRONT) && phase_end)))
        pat_mode <= pattern_sel;
      // Bar counters step once per pixel (after its low byte) and clear in blanking.
      if (!in_href) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (hcnt[0]) begin
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 7'd1;
        end
      end
    end
  end

  assign pixel = pat_mode ? bar_colour : bus.pix_data;
  assign rd_en = !pat_mode;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pixel = bus.pix_data;
  assign rd_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all registered state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state         <= IDLE;
      hcnt          <= '0;
      vcnt          <= '0;
      lo_byte       <= '0;
      bus.cam_vsync <= 1'b0;
      bus.cam_href  <= 1'b0;
      bus.cam_data  <= '0;
      bus.pix_rd    <= 1'b0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (run) state <= VSYNC;
      end else if (!line_end) begin
        hcnt <= hcnt + 1'b1;
      end else begin
        hcnt <= '0;
        vcnt <= phase_end ? '0 : vcnt + 10'd1;
        if (phase_end) begin
          case (state)
            VSYNC:   state <= VBACK;
            VBACK:   state <= ACTIVE;
            ACTIVE:  state <= VFRONT;
            VFRONT:  state <= run ? VSYNC : IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      bus.cam_vsync <= (state == VSYNC);
      bus.cam_href  <= in_href;
      frame_done    <= (state == VFRONT) && phase_end;
      busy          <= (state != IDLE);
      bus.pix_rd    <= rd_en && (rd_pix || rd_pre);

      if (rd_en && rd_pix) begin
        bus.pix_x <= 10'(hcnt >> 1) + 10'd1;
        bus.pix_y <= 9'(vcnt);
      end else if (rd_en && rd_pre) begin
        bus.pix_x <= '0;
        bus.pix_y <= (state == ACTIVE) ? 9'(vcnt + 10'd1) : '0;
      end

      // pix_data is valid now, one cycle after the read; high byte goes out next.
      if (!in_href) begin
        bus.cam_data <= '0;
      end else if (!hcnt[0]) begin
        bus.cam_data <= pixel[15:8];
        lo_byte      <= pixel[7:0];
      end else begin
        bus.cam_data <= lo_byte;
      end
    end
  end

endmodule
